// File: rtl/ibex_fetch_pkg.sv
// Shared types and constants for the instruction fetch request path.
// Slots pair a granted word address with a flag that drops its response.
package ibex_fetch_pkg;

    localparam int unsigned FETCH_WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        discard;
    } fetch_slot_t;

    typedef enum logic {
        FETCH_IDLE     = 1'b0,
        FETCH_WAIT_GNT = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ibex_fetch_req_slots.sv
// In-order queue of outstanding fetch requests: push on grant, pop on response,
// and a bulk discard that marks every queued response to be dropped.
module ibex_fetch_req_slots
    import ibex_fetch_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2,
    parameter bit          ResetAll = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [31:0]                   push_addr_i,
    input  logic                          push_discard_i,
    input  logic                          pop_i,
    input  logic                          discard_all_i,
    output logic [31:0]                   head_addr_o,
    output logic                          head_discard_o,
    output logic [$clog2(NUM_REQS+1)-1:0] cnt_o
);

    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);
    localparam int unsigned PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                pop_eff;
    logic [31:0]         slot_addr [NUM_REQS];
    logic [NUM_REQS-1:0] slot_discard;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQS - 1)) ? '0 : p + 1'b1;
    endfunction

    // A response with nothing outstanding is a leftover from before reset.
    assign pop_eff = pop_i & (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i)  wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_eff) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_eff})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : g_slot
            logic        wr_sel;
            logic [31:0] addr_q;
            logic        discard_q;

            assign wr_sel = push_i & (wr_ptr_q == PTR_W'(gi));

            // The entry written this cycle takes its own discard flag, not the bulk one.
            always_ff @(posedge clk_i) begin
                if (rst_i)              discard_q <= 1'b0;
                else if (wr_sel)        discard_q <= push_discard_i;
                else if (discard_all_i) discard_q <= 1'b1;
            end

            if (ResetAll) begin : g_addr_rst
                always_ff @(posedge clk_i) begin
                    if (rst_i)       addr_q <= '0;
                    else if (wr_sel) addr_q <= push_addr_i;
                end
            end else begin : g_addr_nrst
                always_ff @(posedge clk_i) begin
                    if (wr_sel) addr_q <= push_addr_i;
                end
            end

            assign slot_addr[gi]    = addr_q;
            assign slot_discard[gi] = discard_q;
        end
    endgenerate

    assign head_addr_o    = slot_addr[rd_ptr_q];
    assign head_discard_o = slot_discard[rd_ptr_q];
    assign cnt_o          = cnt_q;

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-bus fetch master: issues word-aligned requests, tracks them in order,
// and forwards surviving responses (with their address) into the fetch FIFO.
module ibex_fetch_req_ctrl
    import ibex_fetch_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2,
    parameter bit          ResetAll = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         branch_addr_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    output logic                busy_o
);

    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);

    fetch_state_e        state_q, state_next;
    logic [31:0]         fetch_addr_q;
    logic [31:0]         req_addr_q;
    logic                wait_discard_q;
    logic [CNT_W-1:0]    out_cnt;
    logic [NUM_REQS-1:0] out_thermo, out_thermo_rev;
    logic                fifo_ready, new_req, issue, granted;
    logic [31:0]         target_addr, head_addr;
    logic                head_discard, head_live;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : g_thermo
            assign out_thermo[gi]     = (out_cnt > CNT_W'(gi));
            assign out_thermo_rev[gi] = out_thermo[NUM_REQS-1-gi];
        end
    endgenerate

    // Room is judged against FIFO occupancy plus responses still in flight.
    assign fifo_ready  = ~&(fifo_busy_i | out_thermo_rev);
    assign new_req     = req_i & (fifo_ready | branch_i) & (out_cnt < CNT_W'(NUM_REQS));
    assign target_addr = word_align(branch_addr_i);
    assign issue       = (state_q == FETCH_IDLE) & new_req;
    assign granted     = instr_req_o & instr_gnt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= FETCH_IDLE;
        else       state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            FETCH_IDLE:     if (new_req && !instr_gnt_i) state_next = FETCH_WAIT_GNT;
            FETCH_WAIT_GNT: if (instr_gnt_i)             state_next = FETCH_IDLE;
            default:        state_next = FETCH_IDLE;
        endcase
    end

    always_comb begin
        instr_req_o  = 1'b0;
        instr_addr_o = fetch_addr_q;
        case (state_q)
            FETCH_IDLE: begin
                instr_req_o  = new_req;
                instr_addr_o = branch_i ? target_addr : fetch_addr_q;
            end
            FETCH_WAIT_GNT: begin
                instr_req_o  = 1'b1;
                instr_addr_o = req_addr_q;
            end
            default: ;
        endcase
    end

    // fetch_addr_q always holds the address after the one on the bus, so a branch
    // while waiting for grant can redirect it without disturbing the pending request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr_q   <= '0;
            wait_discard_q <= 1'b0;
        end else begin
            if (issue)         fetch_addr_q <= instr_addr_o + FETCH_WORD_BYTES;
            else if (branch_i) fetch_addr_q <= target_addr;

            if (state_q != FETCH_WAIT_GNT || instr_gnt_i) wait_discard_q <= 1'b0;
            else if (branch_i)                             wait_discard_q <= 1'b1;
        end
    end

    generate
        if (ResetAll) begin : g_req_addr_rst
            always_ff @(posedge clk_i) begin
                if (rst_i)                      req_addr_q <= '0;
                else if (issue && !instr_gnt_i) req_addr_q <= instr_addr_o;
            end
        end else begin : g_req_addr_nrst
            always_ff @(posedge clk_i) begin
                if (issue && !instr_gnt_i) req_addr_q <= instr_addr_o;
            end
        end
    endgenerate

    ibex_fetch_req_slots #(
        .NUM_REQS (NUM_REQS),
        .ResetAll (ResetAll)
    ) u_slots (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .push_i         (granted),
        .push_addr_i    (instr_addr_o),
        .push_discard_i ((state_q == FETCH_WAIT_GNT) & (branch_i | wait_discard_q)),
        .pop_i          (instr_rvalid_i),
        .discard_all_i  (branch_i),
        .head_addr_o    (head_addr),
        .head_discard_o (head_discard),
        .cnt_o          (out_cnt)
    );

    assign head_live    = (out_cnt != '0);
    assign fifo_clear_o = branch_i;
    assign fifo_valid_o = instr_rvalid_i & head_live & ~head_discard & ~branch_i;
    assign fifo_addr_o  = head_live ? head_addr : '0;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i & fifo_valid_o;
    assign busy_o       = instr_req_o | head_live;

    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)))
        else $error("instr_req_o retracted or instr_addr_o moved before grant");

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        out_cnt <= CNT_W'(NUM_REQS))
        else $error("outstanding count exceeds NUM_REQS");

    a_known: assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown({instr_req_o, instr_addr_o, busy_o, fifo_valid_o,
                     fifo_addr_o, fifo_err_o, fifo_clear_o}))
        else $error("unknown value on a control output");

    // Stray responses are legal after a reset that dropped outstanding requests.
    a_stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_rvalid_i |-> (out_cnt != '0))
        else $warning("instr_rvalid_i with no outstanding request ignored");

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed bench for ibex_fetch_req_ctrl: one stimulus vector per clock,
// outputs sampled shortly after the falling edge against hand-computed values.
module tb_ibex_fetch_req_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic [1:0]  fifo_busy_i = '0;
    logic        fifo_clear_o, fifo_valid_o, fifo_err_o;
    logic [31:0] fifo_addr_o, fifo_rdata_o;
    logic        instr_req_o;
    logic        instr_gnt_i = 1'b0;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_err_i = 1'b0;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_fetch_req_ctrl #(.NUM_REQS(2), .ResetAll(1'b0)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .fifo_busy_i    (fifo_busy_i),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic r, input logic b, input logic [31:0] ba,
                         input logic g, input logic rv, input logic [31:0] rd, input logic e);
        @(negedge clk_i);
        req_i          = r;
        branch_i       = b;
        branch_addr_i  = ba;
        instr_gnt_i    = g;
        instr_rvalid_i = rv;
        instr_rdata_i  = rd;
        instr_err_i    = e;
        #1;
        $display("t=%0t req=%0b br=%0b gnt=%0b rv=%0b | bus req=%0b addr=%08h fifo v=%0b a=%08h d=%08h e=%0b clr=%0b busy=%0b",
                 $time, r, b, g, rv, instr_req_o, instr_addr_o, fifo_valid_o,
                 fifo_addr_o, fifo_rdata_o, fifo_err_o, fifo_clear_o, busy_o);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_req",   32'(instr_req_o), 32'd0);
        chk("rst_addr",  instr_addr_o, 32'h0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_valid", 32'(fifo_valid_o), 32'd0);
        chk("rst_clear", 32'(fifo_clear_o), 32'd0);
        chk("rst_faddr", fifo_addr_o, 32'h0);

        // 1: branch to 0x80 with grant every cycle, responses one cycle later
        apply(1, 1, 32'h80, 1, 0, 32'h0, 0);
        chk("t1_addr0", instr_addr_o, 32'h80);
        chk("t1_clear", 32'(fifo_clear_o), 32'd1);
        chk("t1_req0",  32'(instr_req_o), 32'd1);
        apply(1, 0, 32'h0, 1, 1, 32'hAAAA0080, 0);
        chk("t1_addr1",  instr_addr_o, 32'h84);
        chk("t1_valid0", 32'(fifo_valid_o), 32'd1);
        chk("t1_faddr0", fifo_addr_o, 32'h80);
        chk("t1_rdata0", fifo_rdata_o, 32'hAAAA0080);
        apply(1, 0, 32'h0, 1, 1, 32'hAAAA0084, 0);
        chk("t1_addr2",  instr_addr_o, 32'h88);
        chk("t1_valid1", 32'(fifo_valid_o), 32'd1);
        chk("t1_faddr1", fifo_addr_o, 32'h84);
        chk("t1_rdata1", fifo_rdata_o, 32'hAAAA0084);
        apply(0, 0, 32'h0, 0, 1, 32'hAAAA0088, 0);
        chk("t1_req_off", 32'(instr_req_o), 32'd0);
        chk("t1_faddr2",  fifo_addr_o, 32'h88);
        chk("t1_busy_rsp", 32'(busy_o), 32'd1);
        apply(0, 0, 32'h0, 0, 0, 32'h0, 0);
        chk("t1_idle_busy", 32'(busy_o), 32'd0);

        // 2: request 0x100 stalls for grant, branch to 0x200 meanwhile
        apply(1, 1, 32'h100, 0, 0, 32'h0, 0);
        chk("t2_addr_a", instr_addr_o, 32'h100);
        apply(1, 1, 32'h200, 0, 0, 32'h0, 0);
        chk("t2_addr_b", instr_addr_o, 32'h100);
        chk("t2_clear",  32'(fifo_clear_o), 32'd1);
        chk("t2_req_b",  32'(instr_req_o), 32'd1);
        apply(1, 0, 32'h0, 0, 0, 32'h0, 0);
        chk("t2_addr_c", instr_addr_o, 32'h100);
        apply(1, 0, 32'h0, 1, 0, 32'h0, 0);
        chk("t2_addr_gnt", instr_addr_o, 32'h100);
        apply(1, 0, 32'h0, 1, 1, 32'hBBBB0100, 0);
        chk("t2_addr_tgt", instr_addr_o, 32'h200);
        chk("t2_drop",     32'(fifo_valid_o), 32'd0);
        apply(0, 0, 32'h0, 0, 1, 32'hBBBB0200, 0);
        chk("t2_valid_tgt", 32'(fifo_valid_o), 32'd1);
        chk("t2_faddr_tgt", fifo_addr_o, 32'h200);

        // 3: FIFO reports full; branch pushes two requests then the count limit holds
        fifo_busy_i = 2'b11;
        apply(1, 1, 32'h300, 1, 0, 32'h0, 0);
        chk("t3_req0", 32'(instr_req_o), 32'd1);
        apply(1, 1, 32'h300, 1, 0, 32'h0, 0);
        chk("t3_req1", 32'(instr_req_o), 32'd1);
        apply(1, 0, 32'h0, 1, 0, 32'h0, 0);
        chk("t3_no_req", 32'(instr_req_o), 32'd0);
        chk("t3_busy",   32'(busy_o), 32'd1);
        fifo_busy_i = 2'b00;
        apply(0, 0, 32'h0, 0, 1, 32'h33330300, 0);
        chk("t3_drop", 32'(fifo_valid_o), 32'd0);
        apply(0, 0, 32'h0, 0, 1, 32'h33330304, 0);
        chk("t3_valid", 32'(fifo_valid_o), 32'd1);
        chk("t3_faddr", fifo_addr_o, 32'h300);

        // 4: bus error on a live slot, then on a discarded one
        apply(1, 1, 32'h40, 1, 0, 32'h0, 0);
        chk("t4_addr", instr_addr_o, 32'h40);
        apply(0, 0, 32'h0, 0, 1, 32'hDEAD0040, 1);
        chk("t4_valid", 32'(fifo_valid_o), 32'd1);
        chk("t4_err",   32'(fifo_err_o), 32'd1);
        chk("t4_faddr", fifo_addr_o, 32'h40);
        apply(1, 1, 32'h50, 1, 0, 32'h0, 0);
        apply(0, 1, 32'h60, 0, 0, 32'h0, 0);
        chk("t4_br_noreq", 32'(instr_req_o), 32'd0);
        apply(0, 0, 32'h0, 0, 1, 32'hDEAD0050, 1);
        chk("t4_disc_valid", 32'(fifo_valid_o), 32'd0);

        // 5a: branch with stale-address grant and response in the same cycle
        apply(1, 0, 32'h0, 1, 0, 32'h0, 0);
        chk("t5_addr_60", instr_addr_o, 32'h60);
        apply(1, 0, 32'h0, 0, 0, 32'h0, 0);
        chk("t5_addr_64", instr_addr_o, 32'h64);
        apply(1, 1, 32'h400, 1, 1, 32'hCCCC0060, 0);
        chk("t5_stale_addr", instr_addr_o, 32'h64);
        chk("t5_clear",      32'(fifo_clear_o), 32'd1);
        chk("t5_br_valid",   32'(fifo_valid_o), 32'd0);
        apply(1, 0, 32'h0, 1, 1, 32'hCCCC0064, 0);
        chk("t5_tgt_addr",   instr_addr_o, 32'h400);
        chk("t5_stale_drop", 32'(fifo_valid_o), 32'd0);
        apply(0, 0, 32'h0, 0, 1, 32'hCCCC0400, 0);
        chk("t5_tgt_valid", 32'(fifo_valid_o), 32'd1);
        chk("t5_tgt_faddr", fifo_addr_o, 32'h400);

        // 5b: same collision while idle, so the granted request carries the target
        apply(1, 0, 32'h0, 1, 0, 32'h0, 0);
        chk("t5b_addr", instr_addr_o, 32'h404);
        apply(1, 1, 32'h500, 1, 1, 32'hCCCC0404, 0);
        chk("t5b_tgt_addr", instr_addr_o, 32'h500);
        chk("t5b_clear",    32'(fifo_clear_o), 32'd1);
        chk("t5b_br_valid", 32'(fifo_valid_o), 32'd0);
        apply(0, 0, 32'h0, 0, 1, 32'hCCCC0500, 0);
        chk("t5b_kept_valid", 32'(fifo_valid_o), 32'd1);
        chk("t5b_kept_faddr", fifo_addr_o, 32'h500);

        // 6: reset with two outstanding, stray response, then address wrap
        apply(1, 0, 32'h0, 1, 0, 32'h0, 0);
        chk("t6_addr_504", instr_addr_o, 32'h504);
        apply(1, 0, 32'h0, 1, 0, 32'h0, 0);
        chk("t6_addr_508", instr_addr_o, 32'h508);
        apply(1, 0, 32'h0, 0, 0, 32'h0, 0);
        chk("t6_full_req", 32'(instr_req_o), 32'd0);
        chk("t6_full_busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        apply(0, 0, 32'h0, 0, 1, 32'h5555AAAA, 0);
        chk("t6_stray_valid", 32'(fifo_valid_o), 32'd0);
        chk("t6_stray_busy",  32'(busy_o), 32'd0);
        chk("t6_rst_addr",    instr_addr_o, 32'h0);
        apply(1, 1, 32'hFFFFFFFE, 1, 0, 32'h0, 0);
        chk("t6_top_addr", instr_addr_o, 32'hFFFFFFFC);
        apply(1, 0, 32'h0, 1, 0, 32'h0, 0);
        chk("t6_wrap_addr", instr_addr_o, 32'h0);
        apply(0, 0, 32'h0, 0, 1, 32'h1111FFFC, 0);
        chk("t6_top_valid", 32'(fifo_valid_o), 32'd1);
        chk("t6_top_faddr", fifo_addr_o, 32'hFFFFFFFC);
        apply(0, 0, 32'h0, 0, 1, 32'h11110000, 0);
        chk("t6_wrap_valid", 32'(fifo_valid_o), 32'd1);
        chk("t6_wrap_faddr", fifo_addr_o, 32'h0);
        apply(0, 0, 32'h0, 0, 0, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
